// File: rtl/keypad_pkg.sv
// Shared keypad definitions: keycode constants, debounce and sweep-result enums.
// The calculator datapath imports the same keycode constants.
package keypad_pkg;

    localparam int NUM_ROWS = 5;
    localparam int NUM_COLS = 4;

    localparam logic [4:0] KC_PLUS       = 5'b00001;
    localparam logic [4:0] KC_TIMES      = 5'b00010;
    localparam logic [4:0] KC_EQUALS     = 5'b00011;
    localparam logic [4:0] KC_CA         = 5'b00100;
    localparam int         KC_DIGIT_FLAG = 4;

    typedef enum logic [1:0] {
        IDLE,
        PRESS,
        HELD,
        RELEASE
    } dbState_e;

    typedef enum logic [1:0] {
        NONE,
        ONE,
        MULTI
    } sweepResult_e;

    // Rows 0..3 carry hex digits 4r+c; row 4 carries the function keys.
    function automatic logic [4:0] keyCodeOf(input logic [2:0] row, input logic [1:0] col);
        logic [4:0] kc;
        kc = {1'b1, row[1:0], col};
        if (row == 3'd4) begin
            case (col)
                2'd0:    kc = KC_PLUS;
                2'd1:    kc = KC_TIMES;
                2'd2:    kc = KC_EQUALS;
                default: kc = KC_CA;
            endcase
        end
        return kc;
    endfunction

endpackage

// File: rtl/keypad_sweep.sv
// Column scanner: synchronizes the rows, rotates the column drive and classifies
// each full 4-column sweep as NONE, ONE(code) or MULTI.
module keypad_sweep
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES = 50
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [4:0]   row_n,
    output logic [3:0]   col_n,
    output logic         sweep_done,
    output sweepResult_e result,
    output logic [4:0]   code
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    logic [4:0]    rowMeta_q, rowSync_q;
    logic [1:0]    colIdx_q, colIdx_d;
    logic [SW-1:0] settleCnt_q, settleCnt_d;
    logic [1:0]    hits_q, hits_d;
    logic [4:0]    codeCap_q, codeCap_d;
    logic          sweepDone_q, sweepDone_d;
    sweepResult_e  result_q, result_d;
    logic [4:0]    codeOut_q, codeOut_d;

    logic          lastCycle;
    logic [4:0]    rowLow;
    logic [2:0]    colHits;
    logic [2:0]    sumHits;
    logic [1:0]    nextHits;
    logic [4:0]    colCode;
    logic          firstHit;

    assign col_n      = ~(4'b0001 << colIdx_q);
    assign sweep_done = sweepDone_q;
    assign result     = result_q;
    assign code       = codeOut_q;

    assign lastCycle = (settleCnt_q == SW'(SETTLE_CYCLES - 1));
    assign rowLow    = ~rowSync_q;

    always_comb begin
        colHits = '0;
        colCode = '0;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            colHits = colHits + 3'(rowLow[r]);
            if (rowLow[r]) begin
                colCode = keyCodeOf(3'(r), colIdx_q);
            end
        end
    end

    // Hit count saturates at 2: anything beyond "more than one key" is irrelevant.
    assign sumHits  = {1'b0, hits_q} + colHits;
    assign nextHits = (sumHits >= 3'd2) ? 2'd2 : sumHits[1:0];
    assign firstHit = (colHits == 3'd1) && (hits_q == 2'd0);

    always_comb begin
        settleCnt_d = settleCnt_q + 1'b1;
        colIdx_d    = colIdx_q;
        hits_d      = hits_q;
        codeCap_d   = codeCap_q;
        sweepDone_d = 1'b0;
        result_d    = result_q;
        codeOut_d   = codeOut_q;
        if (lastCycle) begin
            settleCnt_d = '0;
            colIdx_d    = colIdx_q + 2'd1;
            hits_d      = nextHits;
            if (firstHit) begin
                codeCap_d = colCode;
            end
            if (colIdx_q == 2'd3) begin
                sweepDone_d = 1'b1;
                hits_d      = '0;
                codeOut_d   = firstHit ? colCode : codeCap_q;
                case (nextHits)
                    2'd0:    result_d = NONE;
                    2'd1:    result_d = ONE;
                    default: result_d = MULTI;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rowMeta_q   <= '1;
            rowSync_q   <= '1;
            colIdx_q    <= '0;
            settleCnt_q <= '0;
            hits_q      <= '0;
            codeCap_q   <= '0;
            sweepDone_q <= 1'b0;
            result_q    <= NONE;
            codeOut_q   <= '0;
        end else begin
            rowMeta_q   <= row_n;
            rowSync_q   <= rowMeta_q;
            colIdx_q    <= colIdx_d;
            settleCnt_q <= settleCnt_d;
            hits_q      <= hits_d;
            codeCap_q   <= codeCap_d;
            sweepDone_q <= sweepDone_d;
            result_q    <= result_d;
            codeOut_q   <= codeOut_d;
        end
    end

endmodule

// File: rtl/keypad_encoder.sv
// Keypad encoder top: debounces the per-sweep result and emits a one-cycle
// newkey pulse with a held keycode for each accepted press.
module keypad_encoder
    import keypad_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 50,
    parameter int DEBOUNCE_SCANS = 250
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] row_n,
    output logic [3:0] col_n,
    output logic       newkey,
    output logic [4:0] keycode
);

    localparam int CW          = $clog2(DEBOUNCE_SCANS + 1);
    localparam bit SINGLE_SCAN = (DEBOUNCE_SCANS == 1);

    logic         sweepDone;
    sweepResult_e sweepResult;
    logic [4:0]   sweepCode;

    dbState_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]   cand_q, cand_d;
    logic         newkey_q, newkey_d;
    logic [4:0]   keycode_q, keycode_d;

    logic [CW-1:0] cntInc;
    logic          cntFull;

    keypad_sweep #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_sweep (
        .clk       (clk),
        .rst_n     (rst_n),
        .row_n     (row_n),
        .col_n     (col_n),
        .sweep_done(sweepDone),
        .result    (sweepResult),
        .code      (sweepCode)
    );

    assign cntInc  = cnt_q + 1'b1;
    assign cntFull = (cntInc == CW'(DEBOUNCE_SCANS));

    // The FSM only advances on sweep boundaries, so cnt counts whole sweeps.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cand_d    = cand_q;
        newkey_d  = 1'b0;
        keycode_d = keycode_q;
        if (sweepDone) begin
            case (state_q)
                IDLE: begin
                    if (sweepResult == ONE) begin
                        cand_d = sweepCode;
                        cnt_d  = CW'(1);
                        if (SINGLE_SCAN) begin
                            keycode_d = sweepCode;
                            newkey_d  = 1'b1;
                            state_d   = HELD;
                        end else begin
                            state_d = PRESS;
                        end
                    end
                end
                PRESS: begin
                    if (sweepResult == ONE) begin
                        if (sweepCode == cand_q) begin
                            cnt_d = cntInc;
                            if (cntFull) begin
                                keycode_d = cand_q;
                                newkey_d  = 1'b1;
                                state_d   = HELD;
                            end
                        end else begin
                            cand_d = sweepCode;
                            cnt_d  = CW'(1);
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                HELD: begin
                    if (sweepResult == NONE) begin
                        cnt_d   = CW'(1);
                        state_d = SINGLE_SCAN ? IDLE : RELEASE;
                    end
                end
                RELEASE: begin
                    if (sweepResult == NONE) begin
                        cnt_d = cntInc;
                        if (cntFull) begin
                            state_d = IDLE;
                        end
                    end else begin
                        state_d = HELD;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cand_q    <= '0;
            newkey_q  <= 1'b0;
            keycode_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cand_q    <= cand_d;
            newkey_q  <= newkey_d;
            keycode_q <= keycode_d;
        end
    end

    assign newkey  = newkey_q;
    assign keycode = keycode_q;

endmodule

// File: tb/tb_keypad_encoder.sv
// Testbench for keypad_encoder: emulates the key matrix and checks the newkey/keycode
// stream sweep by sweep against a streak-based debounce model.
module tb_keypad_encoder;

    localparam int SETTLE = 4;
    localparam int DEB    = 3;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] row_n;
    logic [3:0] col_n;
    logic       newkey;
    logic [4:0] keycode;

    logic [19:0] pressed = '0;

    int testsRun  = 0;
    int failCount = 0;
    int pulseCnt  = 0;

    bit         armed;
    int         streakKey, streakLen, noneRun;
    logic [4:0] expKeycode;
    int         expPulses;
    bit         pending;

    keypad_encoder #(
        .SETTLE_CYCLES (SETTLE),
        .DEBOUNCE_SCANS(DEB)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .row_n  (row_n),
        .col_n  (col_n),
        .newkey (newkey),
        .keycode(keycode)
    );

    always #5 clk = ~clk;

    // Ideal key matrix: a pressed key shorts its row to its column when that column is low.
    always_comb begin
        row_n = '1;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (newkey === 1'b1) pulseCnt++;
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [19:0] key(input int r, input int c);
        logic [19:0] one;
        one = 20'd1;
        return one << (r*4 + c);
    endfunction

    function automatic int codeOf(input int idx);
        int r, c;
        r = idx / 4;
        c = idx % 4;
        return (r < 4) ? (16 + 4*r + c) : (c + 1);
    endfunction

    task automatic modelReset();
        armed      = 1'b1;
        streakKey  = 0;
        streakLen  = 0;
        noneRun    = 0;
        expKeycode = '0;
        expPulses  = 0;
        pending    = 1'b0;
        pulseCnt   = 0;
    endtask

    // Accept when DEB consecutive sweeps see the same single key while armed;
    // re-arm only after DEB consecutive sweeps with nothing pressed.
    task automatic modelSweep(input logic [19:0] keys);
        int n, k;
        n = $countones(keys);
        k = 0;
        for (int i = 0; i < 20; i++) if (keys[i]) k = codeOf(i);
        if (armed) begin
            if (n == 1) begin
                if (streakLen > 0 && k == streakKey) streakLen++;
                else begin
                    streakKey = k;
                    streakLen = 1;
                end
                if (streakLen == DEB) begin
                    expPulses++;
                    expKeycode = 5'(k);
                    armed      = 1'b0;
                    noneRun    = 0;
                end
            end else begin
                streakLen = 0;
            end
        end else begin
            if (n == 0) begin
                noneRun++;
                if (noneRun == DEB) begin
                    armed     = 1'b1;
                    streakLen = 0;
                end
            end else begin
                noneRun = 0;
            end
        end
        pending = 1'b1;
    endtask

    task automatic checkPending(input string tag);
        if (pending) begin
            checkOutput({tag, "_pulses"}, 32'(pulseCnt), 32'(expPulses));
            checkOutput({tag, "_keycode"}, 32'(keycode), 32'(expKeycode));
            pulseCnt  = 0;
            expPulses = 0;
            pending   = 1'b0;
        end
    endtask

    task automatic waitSweepEnd();
        int guard;
        guard = 0;
        while (col_n == 4'b1110 && guard < 80) begin
            @(negedge clk);
            guard++;
        end
        while (col_n != 4'b1110 && guard < 80) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 80) checkOutput("sweepTimeout", 32'(guard), 32'd0);
    endtask

    // Called at the first negedge of a sweep; holds keys for that whole sweep.
    task automatic applyStimulus(input logic [19:0] keys, input string tag);
        pressed = keys;
        repeat (2) @(negedge clk);
        checkPending(tag);
        modelSweep(keys);
        waitSweepEnd();
    endtask

    task automatic repeatKeys(input logic [19:0] keys, input int n, input string tag);
        for (int i = 0; i < n; i++) applyStimulus(keys, tag);
    endtask

    initial begin
        logic [19:0] cur;
        int sel;

        rst_n   = 1'b0;
        pressed = '0;
        modelReset();
        repeat (3) @(negedge clk);
        checkOutput("reset_col_n", 32'(col_n), 32'h0000000e);
        checkOutput("reset_newkey", 32'(newkey), 32'd0);
        checkOutput("reset_keycode", 32'(keycode), 32'd0);
        rst_n = 1'b1;

        repeatKeys(key(1, 2), 5, "digit6");
        repeatKeys('0, 5, "digit6Rel");

        repeatKeys(key(4, 1), 4, "times");
        repeatKeys('0, 4, "timesRel");
        repeatKeys(key(4, 3), 4, "ca");
        repeatKeys('0, 4, "caRel");

        for (int i = 0; i < 6; i++) applyStimulus((i % 2 == 0) ? key(0, 0) : 20'd0, "bounce");
        repeatKeys(key(0, 0), 4, "bounceHold");
        repeatKeys('0, 4, "bounceRel");

        repeatKeys(key(4, 2), 20, "holdEq");
        repeatKeys(key(4, 2) | key(3, 3), 5, "rollover");
        repeatKeys('0, 4, "rollRel");
        repeatKeys(key(3, 3), 4, "pressF");
        repeatKeys('0, 4, "fRel");

        repeatKeys(key(0, 0) | key(2, 1), 10, "multi");
        repeatKeys(key(0, 0), 4, "multiOne");
        repeatKeys('0, 4, "multiRel");

        cur = '0;
        for (int i = 0; i < 80; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 5) cur = cur;
            else if (sel < 7) cur = '0;
            else if (sel < 9) cur = key(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
            else cur = key(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)))
                     | key(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)));
            applyStimulus(cur, "rand");
        end
        repeatKeys('0, 4, "randRel");
        repeatKeys(key(2, 3), 4, "preResetKey");

        repeat (2) @(negedge clk);
        checkPending("preReset");
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midReset_col_n", 32'(col_n), 32'h0000000e);
        checkOutput("midReset_newkey", 32'(newkey), 32'd0);
        checkOutput("midReset_keycode", 32'(keycode), 32'd0);
        @(negedge clk);
        modelReset();
        rst_n = 1'b1;
        repeatKeys(key(2, 3), 5, "heldThroughReset");
        repeatKeys('0, 4, "postResetRel");

        repeat (2) @(negedge clk);
        checkPending("final");

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
